c_bus_writeback: RTL and testbench

C_BUS_WRITEBACK -- requirements
Module: c_bus_writeback

---
 rtl/c_bus_writeback.sv | 91 +++++++++
 tb/tb_c_bus_writeback.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/c_bus_writeback.sv
// c_bus_writeback: routes bus_in to IR/R/R2/R3/AR or a handshaked memory write.
// Optional CBUS_MEMTIMEOUT_EN adds an 8-bit mem_ack wait counter bounded by TIMEOUT_CYC.
module c_bus_writeback #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bus_in,
    input  logic [2:0]  wr_sel,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic        err_clr,
    output logic [7:0]  IR_out,
    output logic [15:0] R_out,
    output logic [15:0] R2_out,
    output logic [15:0] R3_out,
    output logic [15:0] AR_out,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    output logic        err
);
    typedef enum logic {IDLE, MEM_WAIT} state_t;
    state_t state, nxt;
    logic accept, tmo;
    assign wr_ready = state == IDLE;
    assign mem_we   = state == MEM_WAIT;
    assign accept   = wr_valid && wr_ready;
`ifdef CBUS_MEMTIMEOUT_EN
    logic [7:0] cnt;
    // Timeout fires on the edge that would bring the count to TIMEOUT_CYC; a coincident ack wins.
    assign tmo = state == MEM_WAIT && !mem_ack && cnt == 8'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (accept && wr_sel == 3'b100)
            cnt <= '0;
        else if (state == MEM_WAIT && !mem_ack)
            cnt <= cnt + 8'd1;
    end
`else
    assign tmo = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt;
    end
    always_comb begin
        nxt = state;
        if (state == IDLE)
            nxt = (accept && wr_sel == 3'b100) ? MEM_WAIT : IDLE;
        else
            nxt = (mem_ack || tmo) ? IDLE : MEM_WAIT;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            IR_out    <= '0;
            R_out     <= '0;
            R2_out    <= '0;
            R3_out    <= '0;
            AR_out    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (accept) begin
            case (wr_sel)
                3'b000: IR_out <= bus_in[7:0];
                3'b001: R_out  <= bus_in;
                3'b010: R2_out <= bus_in;
                3'b011: R3_out <= bus_in;
                3'b100: begin
                    mem_addr  <= AR_out[7:0];
                    mem_wdata <= bus_in[7:0];
                end
                3'b101: AR_out <= bus_in;
                default: ;
            endcase
        end
    end
    // err_clr outranks any error raised on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err <= 1'b0;
        else if (err_clr)
            err <= 1'b0;
        else if ((accept && wr_sel[2:1] == 2'b11) || tmo)
            err <= 1'b1;
    end
endmodule

// File: tb/tb_c_bus_writeback.sv
// tb_c_bus_writeback: directed vectors with hand-computed expectations for c_bus_writeback.
module tb_c_bus_writeback;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bus_in = '0;
    logic [2:0]  wr_sel = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic        err_clr = 1'b0;
    logic [7:0]  IR_out;
    logic [15:0] R_out, R2_out, R3_out, AR_out;
    logic        mem_we;
    logic [7:0]  mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic        err;
    int          n_pass = 0;
    int          n_tot = 0;

    c_bus_writeback #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .wr_sel(wr_sel),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .err_clr(err_clr),
        .IR_out(IR_out), .R_out(R_out), .R2_out(R2_out), .R3_out(R3_out),
        .AR_out(AR_out), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tot++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] sel, input logic [15:0] data);
        wr_valid = 1'b1;
        wr_sel   = sel;
        bus_in   = data;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ir"}, {8'h0, IR_out}, 16'h0);
        chk({tag, "_r"}, R_out, 16'h0);
        chk({tag, "_r2"}, R2_out, 16'h0);
        chk({tag, "_r3"}, R3_out, 16'h0);
        chk({tag, "_ar"}, AR_out, 16'h0);
        chk({tag, "_addr"}, {8'h0, mem_addr}, 16'h0);
        chk({tag, "_wdata"}, {8'h0, mem_wdata}, 16'h0);
        chk({tag, "_we"}, {15'h0, mem_we}, 16'h0);
        chk({tag, "_err"}, {15'h0, err}, 16'h0);
    endtask

    initial begin
        #12;
        chk_zero("rst");
        chk("rst_ready", {15'h0, wr_ready}, 16'h1);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", {15'h0, wr_ready}, 16'h1);

        req(3'b001, 16'hA5C3);
        chk("r_load", R_out, 16'hA5C3);
        chk("r_r2", R2_out, 16'h0);
        chk("r_r3", R3_out, 16'h0);
        chk("r_ir", {8'h0, IR_out}, 16'h0);

        req(3'b000, 16'h12F0);
        chk("ir_load", {8'h0, IR_out}, 16'h00F0);
        chk("ir_r_keep", R_out, 16'hA5C3);

        wr_valid = 1'b1; wr_sel = 3'b010; bus_in = 16'h1111;
        step();
        chk("b2b_r2", R2_out, 16'h1111);
        chk("b2b_ready", {15'h0, wr_ready}, 16'h1);
        wr_sel = 3'b011; bus_in = 16'h2222;
        step();
        wr_valid = 1'b0;
        chk("b2b_r3", R3_out, 16'h2222);

        req(3'b101, 16'h0033);
        chk("ar_load", AR_out, 16'h0033);
        req(3'b100, 16'h00BE);
        for (int i = 0; i < 3; i++) begin
            chk("mw_we", {15'h0, mem_we}, 16'h1);
            chk("mw_ready", {15'h0, wr_ready}, 16'h0);
            chk("mw_addr", {8'h0, mem_addr}, 16'h0033);
            chk("mw_wdata", {8'h0, mem_wdata}, 16'h00BE);
            wr_valid = (i < 2);
            wr_sel = 3'b001; bus_in = 16'hFFFF;
            mem_ack = (i == 2);
            step();
        end
        wr_valid = 1'b0; mem_ack = 1'b0;
        chk("mw_done_we", {15'h0, mem_we}, 16'h0);
        chk("mw_done_ready", {15'h0, wr_ready}, 16'h1);
        chk("mw_ignored_r", R_out, 16'hA5C3);

        req(3'b110, 16'h5555);
        chk("ill_err", {15'h0, err}, 16'h1);
        chk("ill_r", R_out, 16'hA5C3);
        chk("ill_ir", {8'h0, IR_out}, 16'h00F0);
        chk("ill_ar", AR_out, 16'h0033);
        chk("ill_ready", {15'h0, wr_ready}, 16'h1);
        err_clr = 1'b1;
        step();
        chk("clr_err", {15'h0, err}, 16'h0);
        req(3'b111, 16'h5555);
        err_clr = 1'b0;
        chk("clr_prio_err", {15'h0, err}, 16'h0);
        req(3'b111, 16'h5555);
        chk("ill111_err", {15'h0, err}, 16'h1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("idle_ack_we", {15'h0, mem_we}, 16'h0);
        chk("idle_ack_ready", {15'h0, wr_ready}, 16'h1);

        req(3'b101, 16'h0044);
        req(3'b100, 16'h0099);
        chk("ar_fwd_addr", {8'h0, mem_addr}, 16'h0044);
        chk("pre_rst_we", {15'h0, mem_we}, 16'h1);
        #2 rst_n = 1'b0;
        #1;
        chk_zero("arst");
        chk("arst_ready", {15'h0, wr_ready}, 16'h1);
        rst_n = 1'b1;
        step();
        chk("rel_ready", {15'h0, wr_ready}, 16'h1);
        step();
        chk("rel_no_retry", {15'h0, mem_we}, 16'h0);

        req(3'b101, 16'h0055);
        req(3'b100, 16'h0077);
`ifdef CBUS_MEMTIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            chk("to_we_hold", {15'h0, mem_we}, 16'h1);
            step();
        end
        chk("to_we", {15'h0, mem_we}, 16'h0);
        chk("to_err", {15'h0, err}, 16'h1);
        chk("to_ready", {15'h0, wr_ready}, 16'h1);
`else
        for (int i = 0; i < 10; i++) begin
            chk("wait_we", {15'h0, mem_we}, 16'h1);
            step();
        end
        chk("wait_err", {15'h0, err}, 16'h0);
        chk("wait_ready", {15'h0, wr_ready}, 16'h0);
        chk("wait_addr", {8'h0, mem_addr}, 16'h0055);
`endif
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
